tdm_demux_8: RTL and testbench

Time-division demultiplexer: the receive end of an 8-to-1 mux serial link. It samples one bit per enabled clock from a single serial line into slot-indexed positions 0..N-1, starting at a frame-sync marker. After the last slot it presents the assembled word with a one-cycle valid strobe. It sits after any 8:1 mux-based serializer in the combinational-circuits chain, so that serializer output can be recovered and checked.

---
 rtl/tdm_pkg.sv | 7 +
 rtl/tdm_slot_counter.sv | 33 +++
 rtl/tdm_demux_8.sv | 97 +++++++++
 tb/tb_tdm_demux_8.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared constants for the TDM demultiplexer: FSM state encoding and default frame geometry.
package tdm_pkg;
    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_RECV   = 1'b1;
    localparam int   TDM_N     = 8;
    localparam int   TDM_SEL_W = 3;
endpackage

// File: rtl/tdm_slot_counter.sv
// Slot index counter for the TDM demultiplexer; load1 restarts a frame at slot 1.
module tdm_slot_counter
    import tdm_pkg::*;
#(
    parameter int N     = TDM_N,
    parameter int SEL_W = TDM_SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load1,
    input  logic             inc,
    output logic [SEL_W-1:0] s,
    output logic             last
);
    logic [SEL_W-1:0] s_reg;

    // A sync restart outranks completion, so load1 wins over clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_reg <= '0;
        end else if (load1) begin
            s_reg <= SEL_W'(1);
        end else if (clear) begin
            s_reg <= '0;
        end else if (inc) begin
            s_reg <= s_reg + SEL_W'(1);
        end
    end

    assign s    = s_reg;
    assign last = (s_reg == SEL_W'(N - 1));
endmodule

// File: rtl/tdm_demux_8.sv
// Receive side of an N:1 TDM serial link: collects one bit per enabled clock
// starting at a sync marker and presents the finished word with a valid strobe.
module tdm_demux_8
    import tdm_pkg::*;
#(
    parameter int N     = TDM_N,
    parameter int SEL_W = TDM_SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync,
    input  logic             din,
    output logic [SEL_W-1:0] s,
    output logic             busy,
    output logic [N-1:0]     q,
    output logic             valid,
    output logic             frame_err
);
    logic             state_reg;
    logic [N-2:0]     shift_reg;
    logic [N-1:0]     q_reg;
    logic             valid_reg;
    logic             frame_err_reg;
    logic [SEL_W-1:0] s_cnt;
    logic             last;
    logic             load1;
    logic             clear;
    logic             inc;
    logic [N-2:0]     wr_sel;

    // Any qualified sync (re)starts a frame, whether idle or mid-frame.
    assign load1 = en && sync;
    assign clear = (state_reg == ST_RECV) && en && !sync && last;
    assign inc   = (state_reg == ST_RECV) && en && !sync && !last;

    tdm_slot_counter #(.N(N), .SEL_W(SEL_W)) u_slot_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .load1 (load1),
        .inc   (inc),
        .s     (s_cnt),
        .last  (last)
    );

    // Slot N-1 never lands in the shift register; it goes straight into q.
    genvar gi;
    generate
        for (gi = 0; gi < N - 1; gi++) begin : g_wr_sel
            assign wr_sel[gi] = (load1 && (gi == 0)) || (inc && (s_cnt == SEL_W'(gi)));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
        end else begin
            for (int i = 0; i < N - 1; i++) begin
                if (wr_sel[i]) begin
                    shift_reg[i] <= din;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            q_reg         <= '0;
            valid_reg     <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            valid_reg     <= 1'b0;
            frame_err_reg <= 1'b0;
            if (state_reg == ST_IDLE) begin
                if (load1) begin
                    state_reg <= ST_RECV;
                end
            end else if (en) begin
                if (sync) begin
                    frame_err_reg <= 1'b1;
                end else if (last) begin
                    q_reg     <= {din, shift_reg};
                    valid_reg <= 1'b1;
                    state_reg <= ST_IDLE;
                end
            end
        end
    end

    assign s         = s_cnt;
    assign busy      = (state_reg == ST_RECV);
    assign q         = q_reg;
    assign valid     = valid_reg;
    assign frame_err = frame_err_reg;
endmodule

// File: tb/tb_tdm_demux_8.sv
// Directed-vector bench for tdm_demux_8: a table of per-edge vectors plus
// hand-written reset sequences.
module tb_tdm_demux_8;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       sync = 1'b0;
    logic       din = 1'b0;
    logic [2:0] s;
    logic       busy;
    logic [7:0] q;
    logic       valid;
    logic       frame_err;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic       en;
        logic       sync;
        logic       din;
        logic [2:0] s;
        logic       busy;
        logic [7:0] q;
        logic       valid;
        logic       err;
    } vec_t;

    vec_t vecs[$];

    tdm_demux_8 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .sync      (sync),
        .din       (din),
        .s         (s),
        .busy      (busy),
        .q         (q),
        .valid     (valid),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic e, input logic sy, input logic d, input logic [2:0] xs,
                                input logic xb, input logic [7:0] xq, input logic xv, input logic xe);
        vec_t v;
        v.en = e; v.sync = sy; v.din = d;
        v.s = xs; v.busy = xb; v.q = xq; v.valid = xv; v.err = xe;
        return v;
    endfunction

    task automatic chk(input string name, input logic [2:0] xs, input logic xb,
                       input logic [7:0] xq, input logic xv, input logic xe);
        n_vec++;
        if (s !== xs || busy !== xb || q !== xq || valid !== xv || frame_err !== xe) begin
            n_err++;
            $display("FAIL %s: got s=%0d busy=%b q=%h valid=%b err=%b, want s=%0d busy=%b q=%h valid=%b err=%b",
                     name, s, busy, q, valid, frame_err, xs, xb, xq, xv, xe);
        end else begin
            $display("ok   %s: s=%0d busy=%b q=%h valid=%b err=%b", name, s, busy, q, valid, frame_err);
        end
    endtask

    task automatic step(input logic e, input logic sy, input logic d);
        @(negedge clk);
        en = e; sync = sy; din = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Frame 0x95 (slots 0..7 = 1,0,1,0,1,0,0,1)
        vecs.push_back(mk(1,1,1, 1,1,8'h00,0,0));
        vecs.push_back(mk(1,0,0, 2,1,8'h00,0,0));
        vecs.push_back(mk(1,0,1, 3,1,8'h00,0,0));
        vecs.push_back(mk(1,0,0, 4,1,8'h00,0,0));
        vecs.push_back(mk(1,0,1, 5,1,8'h00,0,0));
        vecs.push_back(mk(1,0,0, 6,1,8'h00,0,0));
        vecs.push_back(mk(1,0,0, 7,1,8'h00,0,0));
        vecs.push_back(mk(1,0,1, 0,0,8'h95,1,0));
        // Back-to-back frame 0x6A (slots 0..7 = 0,1,0,1,0,1,1,0)
        vecs.push_back(mk(1,1,0, 1,1,8'h95,0,0));
        vecs.push_back(mk(1,0,1, 2,1,8'h95,0,0));
        vecs.push_back(mk(1,0,0, 3,1,8'h95,0,0));
        vecs.push_back(mk(1,0,1, 4,1,8'h95,0,0));
        vecs.push_back(mk(1,0,0, 5,1,8'h95,0,0));
        vecs.push_back(mk(1,0,1, 6,1,8'h95,0,0));
        vecs.push_back(mk(1,0,1, 7,1,8'h95,0,0));
        vecs.push_back(mk(1,0,0, 0,0,8'h6A,1,0));
        // Idle noise: sync without en, en without sync
        vecs.push_back(mk(0,1,1, 0,0,8'h6A,0,0));
        vecs.push_back(mk(0,0,0, 0,0,8'h6A,0,0));
        vecs.push_back(mk(1,0,1, 0,0,8'h6A,0,0));
        vecs.push_back(mk(0,1,0, 0,0,8'h6A,0,0));
        // Gapped frame 0x95 with three disabled cycles after slot 3
        vecs.push_back(mk(1,1,1, 1,1,8'h6A,0,0));
        vecs.push_back(mk(1,0,0, 2,1,8'h6A,0,0));
        vecs.push_back(mk(1,0,1, 3,1,8'h6A,0,0));
        vecs.push_back(mk(1,0,0, 4,1,8'h6A,0,0));
        vecs.push_back(mk(0,0,1, 4,1,8'h6A,0,0));
        vecs.push_back(mk(0,1,0, 4,1,8'h6A,0,0));
        vecs.push_back(mk(0,0,1, 4,1,8'h6A,0,0));
        vecs.push_back(mk(1,0,1, 5,1,8'h6A,0,0));
        vecs.push_back(mk(1,0,0, 6,1,8'h6A,0,0));
        vecs.push_back(mk(1,0,0, 7,1,8'h6A,0,0));
        vecs.push_back(mk(1,0,1, 0,0,8'h95,1,0));
        // Early sync at s=5 with din=1, then 7 slots -> 0x55
        vecs.push_back(mk(1,1,0, 1,1,8'h95,0,0));
        vecs.push_back(mk(1,0,1, 2,1,8'h95,0,0));
        vecs.push_back(mk(1,0,1, 3,1,8'h95,0,0));
        vecs.push_back(mk(1,0,1, 4,1,8'h95,0,0));
        vecs.push_back(mk(1,0,1, 5,1,8'h95,0,0));
        vecs.push_back(mk(1,1,1, 1,1,8'h95,0,1));
        vecs.push_back(mk(1,0,0, 2,1,8'h95,0,0));
        vecs.push_back(mk(1,0,1, 3,1,8'h95,0,0));
        vecs.push_back(mk(1,0,0, 4,1,8'h95,0,0));
        vecs.push_back(mk(1,0,1, 5,1,8'h95,0,0));
        vecs.push_back(mk(1,0,0, 6,1,8'h95,0,0));
        vecs.push_back(mk(1,0,1, 7,1,8'h95,0,0));
        vecs.push_back(mk(1,0,0, 0,0,8'h55,1,0));
        // Sync landing on slot N-1: error and restart beat completion
        vecs.push_back(mk(1,1,1, 1,1,8'h55,0,0));
        vecs.push_back(mk(1,0,0, 2,1,8'h55,0,0));
        vecs.push_back(mk(1,0,0, 3,1,8'h55,0,0));
        vecs.push_back(mk(1,0,0, 4,1,8'h55,0,0));
        vecs.push_back(mk(1,0,0, 5,1,8'h55,0,0));
        vecs.push_back(mk(1,0,0, 6,1,8'h55,0,0));
        vecs.push_back(mk(1,0,0, 7,1,8'h55,0,0));
        vecs.push_back(mk(1,1,0, 1,1,8'h55,0,1));
        vecs.push_back(mk(0,0,1, 1,1,8'h55,0,0));
        vecs.push_back(mk(1,0,1, 2,1,8'h55,0,0));
        vecs.push_back(mk(1,0,1, 3,1,8'h55,0,0));
        vecs.push_back(mk(1,0,1, 4,1,8'h55,0,0));

        // Reset state
        #12;
        chk("reset", 3'd0, 1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].en, vecs[i].sync, vecs[i].din);
            chk($sformatf("vec%0d", i), vecs[i].s, vecs[i].busy, vecs[i].q, vecs[i].valid, vecs[i].err);
        end

        // Asynchronous reset mid-frame (s=4): outputs clear before any edge
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_async", 3'd0, 1'b0, 8'h00, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("rst_mid_held", 3'd0, 1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // din toggling without sync after release: stays idle, q stays 0
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, logic'(i[0]));
            chk($sformatf("post_rst_noise%0d", i), 3'd0, 1'b0, 8'h00, 1'b0, 1'b0);
        end

        // First qualified sync after release starts a frame
        step(1'b1, 1'b1, 1'b1);
        chk("post_rst_sync", 3'd1, 1'b1, 8'h00, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
